data_mem_arbiter: RTL and testbench

//  Shares the single-port 32-word data memory between two requesters: port 0 = CPU load/store

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/data_mem_arbiter_if.sv | 52 +++++
 rtl/data_mem_arbiter_rr_pick2.sv | 20 ++
 rtl/data_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data-memory geometry, arbiter state encoding and port indices.
package cpu_pkg;

   localparam int unsigned CPU_ADDR_W   = 5;
   localparam int unsigned CPU_DATA_W   = 32;
   localparam int unsigned ARB_MAX_LOCK = 4;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_e;

   // Locked state owned by the given port.
   function automatic arb_state_e lock_state(input logic port);
      return port ? LOCK1 : LOCK0;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Two requester ports plus the single-port data memory side of the arbiter.
interface data_mem_arbiter_if
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = CPU_ADDR_W,
   parameter int unsigned DATA_W = CPU_DATA_W
);
   logic              p0_req;
   logic              p0_we;
   logic              p0_lock;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wd;
   logic              p0_gnt;
   logic              p0_rvalid;
   logic [DATA_W-1:0] p0_rd;

   logic              p1_req;
   logic              p1_we;
   logic              p1_lock;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wd;
   logic              p1_gnt;
   logic              p1_rvalid;
   logic [DATA_W-1:0] p1_rd;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wd;
   logic [DATA_W-1:0] mem_rd;

   // Requesters and the memory array.
   modport master (
      output p0_req, p0_we, p0_lock, p0_addr, p0_wd,
      input  p0_gnt, p0_rvalid, p0_rd,
      output p1_req, p1_we, p1_lock, p1_addr, p1_wd,
      input  p1_gnt, p1_rvalid, p1_rd,
      input  mem_en, mem_we, mem_addr, mem_wd,
      output mem_rd
   );

   // The arbiter itself.
   modport slave (
      input  p0_req, p0_we, p0_lock, p0_addr, p0_wd,
      output p0_gnt, p0_rvalid, p0_rd,
      input  p1_req, p1_we, p1_lock, p1_addr, p1_wd,
      output p1_gnt, p1_rvalid, p1_rd,
      output mem_en, mem_we, mem_addr, mem_wd,
      input  mem_rd
   );

endinterface

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the port that was not served last wins.
module rr_pick2
   import cpu_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last == PORT_DBG) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the CPU load/store unit (port 0) and the
// debug/loader port (port 1): round-robin, capped locked bursts, 1-cycle read return.
module data_mem_arbiter
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W   = CPU_ADDR_W,
   parameter int unsigned DATA_W   = CPU_DATA_W,
   parameter int unsigned MAX_LOCK = ARB_MAX_LOCK
) (
   input logic               clk,
   input logic               nreset,
   data_mem_arbiter_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

   arb_state_e        state_q, state_d;
   logic              rr_last_q, rr_last_d;
   logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic              tag_vld_q, tag_vld_d;
   logic              tag_q, tag_d;
   logic [DATA_W-1:0] p0_rd_q, p0_rd_d;
   logic [DATA_W-1:0] p1_rd_q, p1_rd_d;

   logic [1:0]        req;
   logic [1:0]        lock;
   logic [1:0]        pick;
   logic [1:0]        gnt;
   logic              gnt_any;
   logic              gnt_port;
   logic              lock_owner;
   logic              sel_we;
   logic              p0_rvalid_c;
   logic              p1_rvalid_c;
   logic [DATA_W-1:0] p0_rd_c;
   logic [DATA_W-1:0] p1_rd_c;

   assign req  = {bus.p1_req,  bus.p0_req};
   assign lock = {bus.p1_lock, bus.p0_lock};

   rr_pick2 u_rr_pick2 (
      .req  (req),
      .last (rr_last_q),
      .gnt  (pick)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (nreset) begin
         state_q    <= IDLE;
         rr_last_q  <= PORT_DBG;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_last_q  <= rr_last_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // FSM next state: a lock ends on an unlocked beat, a dropped request or the beat cap
   always_comb begin
      state_d    = state_q;
      rr_last_d  = rr_last_q;
      lock_cnt_d = lock_cnt_q;
      lock_owner = (state_q == LOCK1);
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               rr_last_d = gnt_port;
               if (lock[gnt_port]) begin
                  state_d    = lock_state(gnt_port);
                  lock_cnt_d = CNT_W'(1);
               end
            end
         end
         LOCK0, LOCK1: begin
            if (gnt_any && lock[lock_owner] && (32'(lock_cnt_q) + 32'd1 < MAX_LOCK)) begin
               lock_cnt_d = lock_cnt_q + CNT_W'(1);
            end else begin
               state_d    = IDLE;
               lock_cnt_d = '0;
            end
            if (gnt_any) rr_last_d = lock_owner;
         end
         default: begin
            state_d    = IDLE;
            lock_cnt_d = '0;
         end
      endcase
   end

   // FSM outputs: grants are suppressed in reset and restricted to the owner while locked
   always_comb begin
      gnt = 2'b00;
      if (!nreset) begin
         case (state_q)
            IDLE:    gnt = pick;
            LOCK0:   gnt = {1'b0, req[0]};
            LOCK1:   gnt = {req[1], 1'b0};
            default: gnt = 2'b00;
         endcase
      end
   end

   assign gnt_any  = |gnt;
   assign gnt_port = gnt[1];
   assign sel_we   = gnt_port ? bus.p1_we : bus.p0_we;

   assign bus.p0_gnt   = gnt[0];
   assign bus.p1_gnt   = gnt[1];
   assign bus.mem_en   = gnt_any;
   assign bus.mem_we   = gnt_any & sel_we;
   assign bus.mem_addr = !gnt_any ? '0 : (gnt_port ? bus.p1_addr : bus.p0_addr);
   assign bus.mem_wd   = !gnt_any ? '0 : (gnt_port ? bus.p1_wd : bus.p0_wd);

   // Read return: the tag steers mem_rd to the requester one cycle after its read grant
   assign p0_rvalid_c = tag_vld_q & (tag_q == PORT_CPU) & ~nreset;
   assign p1_rvalid_c = tag_vld_q & (tag_q == PORT_DBG) & ~nreset;
   assign p0_rd_c     = p0_rvalid_c ? bus.mem_rd : p0_rd_q;
   assign p1_rd_c     = p1_rvalid_c ? bus.mem_rd : p1_rd_q;

   assign bus.p0_rvalid = p0_rvalid_c;
   assign bus.p1_rvalid = p1_rvalid_c;
   assign bus.p0_rd     = p0_rd_c;
   assign bus.p1_rd     = p1_rd_c;

   always_comb begin
      tag_vld_d = gnt_any & ~sel_we;
      tag_d     = gnt_any ? gnt_port : tag_q;
      p0_rd_d   = p0_rd_c;
      p1_rd_d   = p1_rd_c;
   end

   always_ff @(posedge clk) begin
      if (nreset) begin
         tag_vld_q <= 1'b0;
         tag_q     <= 1'b0;
         p0_rd_q   <= '0;
         p1_rd_q   <= '0;
      end else begin
         tag_vld_q <= tag_vld_d;
         tag_q     <= tag_d;
         p0_rd_q   <= p0_rd_d;
         p1_rd_q   <= p1_rd_d;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model of ownership, round-robin history, pending reads and memory.
module tb_data_mem_arbiter;
   import cpu_pkg::*;

   localparam int unsigned AW = CPU_ADDR_W;
   localparam int unsigned DW = CPU_DATA_W;
   localparam int unsigned ML = ARB_MAX_LOCK;

   logic clk = 1'b0;
   logic nreset;
   always #5 clk = ~clk;

   data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus)
   );

   // Single-port synchronous memory attached to the arbiter
   logic [DW-1:0] ram [32];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wd;
         else            bus.mem_rd <= ram[bus.mem_addr];
      end
   end

   // Stimulus per port
   bit            req [2];
   bit            we  [2];
   bit            lk  [2];
   logic [AW-1:0] ad  [2];
   logic [DW-1:0] wd  [2];

   // Reference model
   logic [DW-1:0] mmem [32];
   int            owner = -1;
   int            beats = 0;
   int            last  = 1;
   bit            pend  = 1'b0;
   int            pend_port = 0;
   logic [DW-1:0] pend_data = '0;
   logic [DW-1:0] exp_rd [2] = '{32'd0, 32'd0};

   int            n_chk  = 0;
   int            n_fail = 0;
   int            g_exp  = -1;
   int            obs_g;
   logic          obs_rv0;
   logic [DW-1:0] obs_rd0;
   int            seq [8];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic apply();
      bus.p0_req = req[0]; bus.p0_we = we[0]; bus.p0_lock = lk[0];
      bus.p0_addr = ad[0]; bus.p0_wd = wd[0];
      bus.p1_req = req[1]; bus.p1_we = we[1]; bus.p1_lock = lk[1];
      bus.p1_addr = ad[1]; bus.p1_wd = wd[1];
   endtask

   task automatic clear_reqs();
      for (int p = 0; p < 2; p++) begin
         req[p] = 1'b0; we[p] = 1'b0; lk[p] = 1'b0; ad[p] = '0; wd[p] = '0;
      end
   endtask

   // One cycle: drive, check at the falling edge, advance the model at the rising edge
   task automatic step();
      int g;
      bit rv;
      apply();
      @(negedge clk);
      g = -1;
      if (!nreset) begin
         if (owner >= 0) begin
            if (req[owner]) g = owner;
         end else if (req[0] && req[1]) g = (last == 0) ? 1 : 0;
         else if (req[0]) g = 0;
         else if (req[1]) g = 1;
      end
      obs_g   = bus.p0_gnt ? 0 : (bus.p1_gnt ? 1 : -1);
      obs_rv0 = bus.p0_rvalid;
      obs_rd0 = bus.p0_rd;
      chk("p0_gnt", 32'(bus.p0_gnt), 32'(g == 0));
      chk("p1_gnt", 32'(bus.p1_gnt), 32'(g == 1));
      chk("mem_en", 32'(bus.mem_en), 32'(g >= 0));
      chk("mem_we", 32'(bus.mem_we), (g >= 0) ? 32'(we[g]) : 32'd0);
      chk("mem_addr", 32'(bus.mem_addr), (g >= 0) ? 32'(ad[g]) : 32'd0);
      chk("mem_wd", 32'(bus.mem_wd), (g >= 0) ? 32'(wd[g]) : 32'd0);
      for (int p = 0; p < 2; p++) begin
         rv = !nreset && pend && (pend_port == p);
         chk($sformatf("p%0d_rvalid", p),
             32'(p == 0 ? bus.p0_rvalid : bus.p1_rvalid), 32'(rv));
         chk($sformatf("p%0d_rd", p),
             32'(p == 0 ? bus.p0_rd : bus.p1_rd), 32'(rv ? pend_data : exp_rd[p]));
      end
      @(posedge clk);
      if (nreset) begin
         owner = -1; beats = 0; last = 1; pend = 1'b0;
         exp_rd[0] = '0; exp_rd[1] = '0;
      end else begin
         if (pend) exp_rd[pend_port] = pend_data;
         pend = 1'b0;
         if (g >= 0) begin
            if (we[g]) mmem[ad[g]] = wd[g];
            else begin
               pend = 1'b1; pend_port = g; pend_data = mmem[ad[g]];
            end
            last = g;
            if (owner < 0) begin
               if (lk[g]) begin owner = g; beats = 1; end
            end else if (lk[g] && (beats + 1 < int'(ML))) beats++;
            else begin owner = -1; beats = 0; end
         end else if (owner >= 0) begin
            owner = -1; beats = 0;
         end
      end
      g_exp = g;
      #1;
   endtask

   initial begin
      int k;
      bit p0_done;
      clear_reqs();
      nreset = 1'b1;
      apply();
      @(posedge clk);
      #1;

      // Reset holds off both requesters
      req[0] = 1'b1; req[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset_gnt", 32'(obs_g), 32'hFFFF_FFFF);
      end
      nreset = 1'b0;
      clear_reqs();

      // Loader port preloads every word
      for (int i = 0; i < 32; i++) begin
         req[1] = 1'b1; we[1] = 1'b1; ad[1] = AW'(i); wd[1] = $urandom;
         step();
      end
      clear_reqs();
      step();

      // Tie: port 0 first, then alternate
      req[0] = 1'b1; ad[0] = AW'(3);
      req[1] = 1'b1; ad[1] = AW'(7);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("tie_seq", 32'(obs_g), 32'(i % 2));
      end
      clear_reqs();
      step();

      // Locked burst from port 1 is capped; port 0 gets in after four beats
      k = 0;
      req[0] = 1'b1; ad[0] = '0;
      for (int c = 0; c < 8 && k < 6; c++) begin
         req[1] = 1'b1; we[1] = 1'b1; lk[1] = (k < 5); ad[1] = AW'(k); wd[1] = 32'hA + 32'(k);
         step();
         seq[c] = obs_g;
         if (g_exp == 1) k++;
         if (g_exp == 0) req[0] = 1'b0;
      end
      chk("burst_beats", 32'(k), 32'd6);
      for (int c = 0; c < 6; c++) chk("burst_seq", 32'(seq[c]), (c == 4) ? 32'd0 : 32'd1);
      clear_reqs();
      for (int i = 0; i < 7; i++) begin
         req[0] = (i < 6); ad[0] = AW'(i);
         step();
         if (i > 0) begin
            chk("burst_rv", 32'(obs_rv0), 32'd1);
            chk("burst_rd", obs_rd0, 32'hA + 32'(i - 1));
         end
      end

      // Lock released early by an unlocked beat
      clear_reqs();
      k = 0; p0_done = 1'b0;
      for (int c = 0; c < 8 && k < 3; c++) begin
         req[1] = 1'b1; we[1] = 1'b1; ad[1] = AW'(8 + k); wd[1] = $urandom; lk[1] = (k < 2);
         req[0] = (k >= 1);
         step();
         chk("lockdrop_seq", 32'(obs_g), 32'd1);
         if (g_exp == 1) k++;
      end
      we[1] = 1'b0; lk[1] = 1'b0;
      step();
      chk("lockdrop_p0", 32'(obs_g), 32'd0);
      clear_reqs();
      step();

      // Write then read the top address
      req[0] = 1'b1; we[0] = 1'b1; ad[0] = AW'(31); wd[0] = 32'h1234;
      step();
      chk("raw_wr_gnt", 32'(obs_g), 32'd0);
      we[0] = 1'b0;
      step();
      req[0] = 1'b0;
      step();
      chk("raw_rv", 32'(obs_rv0), 32'd1);
      chk("raw_rd", obs_rd0, 32'h1234);

      // Reset right after a read grant drops the return
      req[0] = 1'b1; ad[0] = AW'(5);
      step();
      nreset = 1'b1; req[0] = 1'b0;
      step();
      chk("rst_rv", 32'(obs_rv0), 32'd0);
      nreset = 1'b0;
      step();
      chk("rst_rv_after", 32'(obs_rv0), 32'd0);

      // Random traffic; requests are held until granted
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!req[p] || g_exp == p) begin
               req[p] = ($urandom_range(0, 3) != 0);
               we[p]  = $urandom_range(0, 1) == 1;
               lk[p]  = ($urandom_range(0, 3) != 0);
               ad[p]  = AW'($urandom);
               wd[p]  = $urandom;
            end
         end
         nreset = ($urandom_range(0, 199) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
